// File: rtl/uart_cmd_decoder.sv
// Hamming(7,4) command decoder between uart_rx and uart_tx: sets out_en, answers each byte with ACK/NAK, watchdog forces output off.
// Optional macro HAMMING_CORRECT_EN: single-bit correction instead of detection-only.
module uart_cmd_decoder #(
  parameter logic [7:0]  ACK_BYTE       = 8'h3C,
  parameter logic [7:0]  NAK_BYTE       = 8'hC3,
  parameter int unsigned TIMEOUT_CYCLES = 48000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_received,
  input  logic       rx_done,
  input  logic       parity_error,
  input  logic       tx_busy,
  output logic [7:0] data_to_tx,
  output logic       start_tx,
  output logic       out_en,
  output logic       cmd_valid,
  output logic [3:0] cmd_nibble,
  output logic       timeout,
  output logic       overrun
);

  localparam logic [3:0]       CMD_ON     = 4'h6;
  localparam logic [3:0]       CMD_OFF    = 4'hD;
  localparam logic [3:0]       CMD_TOGGLE = 4'h9;
  localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]       SYN_MASK [3] = '{7'b1010101, 7'b1100110, 7'b1111000};
  localparam int               DATA_IDX [4] = '{2, 4, 5, 6};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    REQ       = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [7:0] hold_data_reg;
  logic       hold_perr_reg;
  logic       hold_full_reg;
  logic       overrun_reg;
  logic       entry_free;

  logic [6:0] codeword;
  logic [2:0] syndrome;
  logic [3:0] nibble;
  logic       syndrome_ok;
  logic       cmd_known;
  logic       accept;

  logic             out_en_reg, out_en_next;
  logic             cmd_valid_reg, cmd_valid_next;
  logic [3:0]       cmd_nibble_reg, cmd_nibble_next;
  logic             timeout_reg, timeout_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic [CNT_W-1:0] wdog_cnt_reg, wdog_cnt_next;

  // The entry is released in DECODE; a byte arriving that same cycle still lands.
  assign entry_free = (state_reg == DECODE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_data_reg <= '0;
      hold_perr_reg <= 1'b0;
      hold_full_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (rx_done && (!hold_full_reg || entry_free)) begin
        hold_data_reg <= data_received;
        hold_perr_reg <= parity_error;
        hold_full_reg <= 1'b1;
      end else if (entry_free) begin
        hold_full_reg <= 1'b0;
      end
      if (rx_done && hold_full_reg && !entry_free) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign codeword = hold_data_reg[6:0];

  for (genvar gi = 0; gi < 3; gi++) begin : g_syndrome
    assign syndrome[gi] = ^(codeword & SYN_MASK[gi]);
  end

  // Flipping a parity position never changes the nibble, so only data positions need a fix path.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
`ifdef HAMMING_CORRECT_EN
    assign nibble[gi] = codeword[DATA_IDX[gi]] ^ (syndrome == 3'(DATA_IDX[gi] + 1));
`else
    assign nibble[gi] = codeword[DATA_IDX[gi]];
`endif
  end

`ifdef HAMMING_CORRECT_EN
  assign syndrome_ok = 1'b1;
`else
  assign syndrome_ok = (syndrome == 3'd0);
`endif

  assign cmd_known = (nibble == CMD_ON) || (nibble == CMD_OFF) || (nibble == CMD_TOGGLE);
  assign accept    = !hold_perr_reg && hold_data_reg[7] && syndrome_ok && cmd_known;

  always_comb begin
    out_en_next     = out_en_reg;
    cmd_valid_next  = 1'b0;
    cmd_nibble_next = cmd_nibble_reg;
    timeout_next    = 1'b0;
    tx_data_next    = tx_data_reg;
    wdog_cnt_next   = '0;

    if (out_en_reg) begin
      if (wdog_cnt_reg == WDOG_LAST) begin
        out_en_next   = 1'b0;
        timeout_next  = 1'b1;
        wdog_cnt_next = '0;
      end else begin
        wdog_cnt_next = wdog_cnt_reg + CNT_W'(1);
      end
    end

    // An accepted command overrides a watchdog expiry landing in the same cycle.
    if (state_reg == DECODE) begin
      if (accept) begin
        case (nibble)
          CMD_ON:  out_en_next = 1'b1;
          CMD_OFF: out_en_next = 1'b0;
          default: out_en_next = ~out_en_reg;
        endcase
        cmd_nibble_next = nibble;
        cmd_valid_next  = 1'b1;
        timeout_next    = 1'b0;
        wdog_cnt_next   = '0;
        tx_data_next    = ACK_BYTE;
      end else begin
        tx_data_next = NAK_BYTE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_en_reg     <= 1'b0;
      cmd_valid_reg  <= 1'b0;
      cmd_nibble_reg <= '0;
      timeout_reg    <= 1'b0;
      tx_data_reg    <= '0;
      wdog_cnt_reg   <= '0;
    end else begin
      out_en_reg     <= out_en_next;
      cmd_valid_reg  <= cmd_valid_next;
      cmd_nibble_reg <= cmd_nibble_next;
      timeout_reg    <= timeout_next;
      tx_data_reg    <= tx_data_next;
      wdog_cnt_reg   <= wdog_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (hold_full_reg) state_next = DECODE;
      DECODE:    state_next = REQ;
      REQ:       if (tx_busy) state_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    start_tx = (state_reg == REQ);
  end

  assign data_to_tx = tx_data_reg;
  assign out_en     = out_en_reg;
  assign cmd_valid  = cmd_valid_reg;
  assign cmd_nibble = cmd_nibble_reg;
  assign timeout    = timeout_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: command table, watchdog timing, overrun and reset corners.
module tb_uart_cmd_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] data_received;
  logic       rx_done;
  logic       parity_error;
  logic       tx_busy;
  logic [7:0] data_to_tx;
  logic       start_tx;
  logic       out_en;
  logic       cmd_valid;
  logic [3:0] cmd_nibble;
  logic       timeout;
  logic       overrun;

  logic       force_busy = 1'b0;
  logic       tx_en      = 1'b1;
  logic       model_busy = 1'b0;
  int         busy_cnt   = 0;
  logic [7:0] resp_q [$];

  int tests_run    = 0;
  int tests_failed = 0;

  assign tx_busy = model_busy | force_busy;

  uart_cmd_decoder #(
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_received (data_received),
    .rx_done       (rx_done),
    .parity_error  (parity_error),
    .tx_busy       (tx_busy),
    .data_to_tx    (data_to_tx),
    .start_tx      (start_tx),
    .out_en        (out_en),
    .cmd_valid     (cmd_valid),
    .cmd_nibble    (cmd_nibble),
    .timeout       (timeout),
    .overrun       (overrun)
  );

  // uart_tx stand-in: accepts start_tx, logs the byte, stays busy for 4 cycles.
  always @(negedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) model_busy = 1'b0;
    end else if (tx_en && start_tx) begin
      model_busy = 1'b1;
      busy_cnt   = 4;
      resp_q.push_back(data_to_tx);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       exp_out_en;
    logic       exp_ack;
    logic       exp_valid;
    logic [3:0] exp_nibble;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pe);
    @(negedge clk);
    data_received = d;
    parity_error  = pe;
    rx_done       = 1'b1;
    @(negedge clk);
    rx_done      = 1'b0;
    parity_error = 1'b0;
  endtask

  task automatic wait_resp_done(input string tag);
    int n;
    n = 0;
    while (!model_busy && n < 60) begin @(negedge clk); n++; end
    while (model_busy && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: tx handshake not completed within 60 cycles", tag);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "bench stalled");
  end

  initial begin
    logic       prev_en;
    logic       early;
    int         nresp;
    logic [7:0] exp_byte;

    vecs[0] = '{8'hB3, 1'b0, 1'b1, 1'b1, 1'b1, 4'h6};
    vecs[1] = '{8'hE6, 1'b0, 1'b0, 1'b1, 1'b1, 4'hD};
    vecs[2] = '{8'hCC, 1'b0, 1'b1, 1'b1, 1'b1, 4'h9};
`ifdef HAMMING_CORRECT_EN
    vecs[3] = '{8'hA3, 1'b0, 1'b1, 1'b1, 1'b1, 4'h6};
`else
    vecs[3] = '{8'hA3, 1'b0, 1'b1, 1'b0, 1'b0, 4'h9};
`endif
    vecs[4] = '{8'hE6, 1'b0, 1'b0, 1'b1, 1'b1, 4'hD};
    vecs[5] = '{8'hB3, 1'b1, 1'b0, 1'b0, 1'b0, 4'hD};
    vecs[6] = '{8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 4'hD};
    vecs[7] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 4'hD};
    vecs[8] = '{8'hCC, 1'b0, 1'b1, 1'b1, 1'b1, 4'h9};
    vecs[9] = '{8'hCC, 1'b0, 1'b0, 1'b1, 1'b1, 4'h9};

    reset         = 1'b0;
    data_received = 8'h00;
    rx_done       = 1'b0;
    parity_error  = 1'b0;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_data_to_tx", data_to_tx, 8'h00);
    check("rst_start_tx",   start_tx,   1'b0);
    check("rst_out_en",     out_en,     1'b0);
    check("rst_cmd_valid",  cmd_valid,  1'b0);
    check("rst_cmd_nibble", cmd_nibble, 4'h0);
    check("rst_timeout",    timeout,    1'b0);
    check("rst_overrun",    overrun,    1'b0);

    for (int i = 0; i < 10; i++) begin
      prev_en  = out_en;
      nresp    = resp_q.size();
      exp_byte = vecs[i].exp_ack ? 8'h3C : 8'hC3;
      send(vecs[i].data, vecs[i].perr);
      @(negedge clk);
      check($sformatf("v%0d_out_en_latency", i), out_en, prev_en);
      check($sformatf("v%0d_start_early", i), start_tx, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_out_en", i), out_en, vecs[i].exp_out_en);
      check($sformatf("v%0d_cmd_valid", i), cmd_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_cmd_nibble", i), cmd_nibble, vecs[i].exp_nibble);
      check($sformatf("v%0d_start_tx", i), start_tx, 1'b1);
      check($sformatf("v%0d_data_to_tx", i), data_to_tx, exp_byte);
      @(negedge clk);
      check($sformatf("v%0d_cmd_valid_width", i), cmd_valid, 1'b0);
      wait_resp_done($sformatf("v%0d_handshake", i));
      check($sformatf("v%0d_resp_count", i), resp_q.size(), nresp + 1);
      if (resp_q.size() > 0)
        check($sformatf("v%0d_resp_byte", i), resp_q[resp_q.size() - 1], exp_byte);
      $display("[TB] vec %0d: byte %02h perr %0b -> out_en %0b nibble %0h reply %02h",
               i, vecs[i].data, vecs[i].perr, out_en, cmd_nibble, data_to_tx);
    end

    // Watchdog: expiry exactly 100 cycles after the accepting edge, with no reply byte.
    nresp = resp_q.size();
    send(8'hB3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("wd_on", out_en, 1'b1);
    early = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (k < 100 && (timeout || !out_en)) early = 1'b1;
      if (k == 100) begin
        check("wd_timeout_pulse", timeout, 1'b1);
        check("wd_out_en_off", out_en, 1'b0);
      end
      if (k == 101) check("wd_timeout_width", timeout, 1'b0);
    end
    check("wd_no_early", early, 1'b0);
    check("wd_no_reply_on_expiry", resp_q.size(), nresp + 1);
    $display("[TB] watchdog: single accept, expiry at cycle 100");

    // Re-sent command at cycle 90 restarts the watchdog.
    send(8'hB3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("wd2_on", out_en, 1'b1);
    early = 1'b0;
    for (int k = 1; k <= 190; k++) begin
      @(negedge clk);
      if (k == 87) begin
        data_received = 8'hB3;
        rx_done       = 1'b1;
      end
      if (k == 88) rx_done = 1'b0;
      if (k == 90) check("wd2_reaccept", cmd_valid, 1'b1);
      if (k < 190 && timeout) early = 1'b1;
      if (k == 190) begin
        check("wd2_timeout_pulse", timeout, 1'b1);
        check("wd2_out_en_off", out_en, 1'b0);
      end
    end
    check("wd2_no_early", early, 1'b0);
    $display("[TB] watchdog: re-accept at 90, expiry at cycle 190");

    // Overrun: second byte held while tx is busy, third dropped.
    nresp      = resp_q.size();
    force_busy = 1'b1;
    send(8'hB3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("ov_start_tx", start_tx, 1'b1);
    repeat (3) @(negedge clk);
    send(8'hE6, 1'b0);
    repeat (2) @(negedge clk);
    check("ov_held_no_overrun", overrun, 1'b0);
    send(8'hCC, 1'b0);
    check("ov_overrun_set", overrun, 1'b1);
    check("ov_out_en_still_on", out_en, 1'b1);
    force_busy = 1'b0;
    wait_resp_done("ov_handshake");
    check("ov_resp_count", resp_q.size(), nresp + 2);
    check("ov_out_en", out_en, 1'b0);
    check("ov_cmd_nibble", cmd_nibble, 4'hD);
    check("ov_sticky", overrun, 1'b1);
    $display("[TB] overrun: B3 E6 CC under busy -> %0d replies, out_en %0b",
             resp_q.size() - nresp, out_en);

    // Reset while a request is pending with no uart_tx response.
    tx_en = 1'b0;
    send(8'hB3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("rr_start_held", start_tx, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("rr_start_drop", start_tx, 1'b0);
    check("rr_out_en", out_en, 1'b0);
    check("rr_overrun_clear", overrun, 1'b0);
    check("rr_data_to_tx", data_to_tx, 8'h00);
    check("rr_cmd_nibble", cmd_nibble, 4'h0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rr_idle_after", start_tx, 1'b0);
    tx_en = 1'b1;
    $display("[TB] reset during request: start_tx %0b overrun %0b", start_tx, overrun);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
